// File: rtl/sd_cmd_serial_card.sv
// Card-side SD CMD line engine: receives 48-bit host commands, checks framing
// and CRC7, hands content over valid/ack, then sends a 48-bit short response.
//   state  | meaning
//   S_IDLE | line released, hunting for a start bit
//   S_RX   | shifting in command bits 1..47
//   S_HOLD | command presented on CMD_OUT, waiting for CMD_ACK
//   S_WAIT | counting the NCR gap before the response
//   S_TX   | driving the 48 response bits
module sd_cmd_serial_card #(
  parameter int NCR = 2
) (
  input  logic        SD_CLK_IN,
  input  logic        RST_N_IN,
  input  logic        cmd_dat_i,
  output logic        cmd_out_o,
  output logic        cmd_oe_o,
  output logic [39:0] CMD_OUT,
  output logic        CMD_VALID,
  output logic        CRC_ERR,
  input  logic        CMD_ACK,
  input  logic        RSP_EN,
  input  logic        RSP_NO_CRC,
  input  logic [37:0] RSP_IN,
  output logic        BUSY
);

  typedef enum logic [2:0] {S_IDLE, S_RX, S_HOLD, S_WAIT, S_TX} state_t;

  localparam logic [5:0] NCR_TC = 6'(NCR - 1);

  state_t      state;
  logic [5:0]  bit_cnt;
  logic [5:0]  dly_cnt;
  logic [6:0]  crc;
  logic [6:0]  rx_crc;
  logic [38:0] content;
  logic [39:0] tx_sr;
  logic        no_crc;
  logic        tx_bit;
  logic        tx_go;

  function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
    logic fb;
    fb = c[6] ^ b;
    return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  endfunction

  // bit_cnt doubles as the index of the response bit being driven this edge
  always_comb begin
    tx_bit = 1'b1;
    if (bit_cnt < 6'd40)      tx_bit = tx_sr[39];
    else if (bit_cnt < 6'd47) tx_bit = no_crc | crc[6];
  end

  assign tx_go = ((state == S_WAIT) && (dly_cnt == NCR_TC)) ||
                 ((state == S_TX) && (bit_cnt != 6'd48));
  assign BUSY  = (state != S_IDLE);

  always_ff @(posedge SD_CLK_IN or negedge RST_N_IN) begin
    if (!RST_N_IN) begin
      state     <= S_IDLE;
      bit_cnt   <= '0;
      dly_cnt   <= '0;
      crc       <= '0;
      rx_crc    <= '0;
      content   <= '0;
      tx_sr     <= '0;
      no_crc    <= 1'b0;
      cmd_out_o <= 1'b1;
      cmd_oe_o  <= 1'b0;
      CMD_OUT   <= '0;
      CMD_VALID <= 1'b0;
      CRC_ERR   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          cmd_oe_o  <= 1'b0;
          cmd_out_o <= 1'b1;
          if (!cmd_dat_i) begin
            state   <= S_RX;
            bit_cnt <= 6'd1;
            crc     <= crc7_step(7'd0, cmd_dat_i);
          end
        end
        S_RX: begin
          bit_cnt <= bit_cnt + 6'd1;
          if ((bit_cnt == 6'd1) && !cmd_dat_i) begin
            state   <= S_IDLE;
            bit_cnt <= '0;
          end else if (bit_cnt <= 6'd39) begin
            content <= {content[37:0], cmd_dat_i};
            crc     <= crc7_step(crc, cmd_dat_i);
          end else if (bit_cnt <= 6'd46) begin
            rx_crc  <= {rx_crc[5:0], cmd_dat_i};
          end else begin
            bit_cnt <= '0;
            if (cmd_dat_i) begin
              CMD_OUT   <= {1'b0, content};
              CMD_VALID <= 1'b1;
              CRC_ERR   <= (rx_crc != crc);
              state     <= S_HOLD;
            end else begin
              state     <= S_IDLE;
            end
          end
        end
        S_HOLD: begin
          if (CMD_ACK) begin
            CMD_VALID <= 1'b0;
            tx_sr     <= {2'b00, RSP_IN};
            no_crc    <= RSP_NO_CRC;
            crc       <= '0;
            bit_cnt   <= '0;
            dly_cnt   <= '0;
            state     <= (!RSP_EN || CRC_ERR) ? S_IDLE : S_WAIT;
          end
        end
        S_WAIT: begin
          if (dly_cnt == NCR_TC) state <= S_TX;
          else                   dly_cnt <= dly_cnt + 6'd1;
        end
        S_TX: begin
          if (bit_cnt == 6'd48) begin
            cmd_oe_o  <= 1'b0;
            cmd_out_o <= 1'b1;
            bit_cnt   <= '0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase

      if (tx_go) begin
        cmd_oe_o  <= 1'b1;
        cmd_out_o <= tx_bit;
        bit_cnt   <= bit_cnt + 6'd1;
        if (bit_cnt < 6'd40) begin
          tx_sr <= {tx_sr[38:0], 1'b0};
          crc   <= crc7_step(crc, tx_bit);
        end else if (bit_cnt < 6'd47) begin
          crc   <= {crc[5:0], 1'b0};
        end
      end
    end
  end

endmodule
